wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback and one long-latency (LL) unit, e.g. a multiply/divide unit.
- The pipeline write always wins. LL results wait in a small FIFO and drain into idle writeback slots.
- A starvation counter forces a pipeline bubble when an LL result has waited too long.
- A lookup port tells issue logic whether a register still has a queued LL write, so it can stall.

---
 rtl/wb_port_arbiter_pkg.sv | 24 ++
 rtl/wb_ll_fifo.sv | 110 +++++++++++
 rtl/wb_port_arbiter.sv | 118 +++++++++++
 tb/tb_wb_port_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback-port arbiter: the write-port request, the source select
// enum and the x0 constant.
package wb_port_arbiter_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_RA_W = 5;

    localparam logic [WB_RA_W-1:0] RD_ZERO = '0;

    // Field widths follow the package widths; the arbiter's XLEN/RA_W defaults match them.
    typedef struct packed {
        logic               wen;
        logic [WB_RA_W-1:0] rd;
        logic [WB_XLEN-1:0] wdata;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_FIFO,
        SRC_BYPASS
    } wb_src_e;

endpackage

// File: rtl/wb_ll_fifo.sv
// Long-latency result queue with per-entry valid bits.
// Supports register-match invalidation and an associative lookup for issue stalls.
module wb_ll_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN    = WB_XLEN,
    parameter int RA_W    = WB_RA_W,
    parameter int Q_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [RA_W-1:0] push_rd,
    input  logic [XLEN-1:0] push_wdata,
    input  logic            pop,
    input  logic            kill,
    input  logic [RA_W-1:0] kill_rd,
    input  logic [RA_W-1:0] chk_rd,
    output logic            chk_hit,
    output logic            live_any,
    output logic [RA_W-1:0] head_rd,
    output logic [XLEN-1:0] head_wdata,
    output logic            full,
    output logic            retire
);

    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [Q_DEPTH-1:0] valid;
    logic [RA_W-1:0]    rd_q   [Q_DEPTH];
    logic [XLEN-1:0]    data_q [Q_DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count;

    logic [Q_DEPTH-1:0] live, hit;
    logic               found;
    logic [PTR_W-1:0]   first_off, first_idx;
    logic [CNT_W-1:0]   retire_n;

    // Entries killed this cycle are already treated as gone for selection.
    always_comb begin
        live = '0;
        hit  = '0;
        for (int i = 0; i < Q_DEPTH; i++) begin
            live[i] = valid[i] && !(kill && rd_q[i] == kill_rd);
            hit[i]  = valid[i] && rd_q[i] == chk_rd;
        end
    end

    always_comb begin
        found     = 1'b0;
        first_off = '0;
        for (int i = 0; i < Q_DEPTH; i++) begin
            if (!found && live[head + PTR_W'(i)]) begin
                found     = 1'b1;
                first_off = PTR_W'(i);
            end
        end
    end

    assign first_idx  = head + first_off;
    assign head_rd    = rd_q[first_idx];
    assign head_wdata = data_q[first_idx];
    assign live_any   = found;
    assign chk_hit    = |hit;
    assign full       = (count == CNT_W'(Q_DEPTH));

    // A pop retires the dead entries in front of the popped one; otherwise a dead head
    // is reclaimed on its own so it never blocks ll_ready.
    always_comb begin
        retire_n = '0;
        if (pop && found)
            retire_n = CNT_W'(first_off) + CNT_W'(1);
        else if (count != '0 && !valid[head])
            retire_n = CNT_W'(1);
    end
    assign retire = (retire_n != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                if (kill && rd_q[i] == kill_rd)
                    valid[i] <= 1'b0;
                if (CNT_W'(i) < retire_n)
                    valid[head + PTR_W'(i)] <= 1'b0;
            end
            // When full, tail aliases the retiring head slot; the push must win.
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            head  <= head + PTR_W'(retire_n);
            count <= count - retire_n + CNT_W'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail]   <= push_rd;
            data_q[tail] <= push_wdata;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and a
// long-latency unit; LL results queue and drain into idle slots, with a starvation hold.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN         = WB_XLEN,
    parameter int RA_W         = WB_RA_W,
    parameter int Q_DEPTH      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_wen,
    input  logic [RA_W-1:0] pipe_rd,
    input  logic [XLEN-1:0] pipe_wdata,
    input  logic            ll_valid,
    input  logic [RA_W-1:0] ll_rd,
    input  logic [XLEN-1:0] ll_wdata,
    output logic            ll_ready,
    output logic            pipe_hold,
    input  logic [RA_W-1:0] chk_rd,
    output logic            chk_hit,
    output logic            rf_wen,
    output logic [RA_W-1:0] rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    localparam logic [RA_W-1:0] X0    = RA_W'(RD_ZERO);
    localparam logic [3:0]      LIMIT = 4'(STARVE_LIMIT);

    logic            pipe_wr, ll_fire, push, pop;
    logic            fifo_hit, live_any, full, retire;
    logic [RA_W-1:0] head_rd;
    logic [XLEN-1:0] head_wdata;
    wb_src_e         sel;
    wb_req_t         req_d, req_q;
    logic [3:0]      starve_q, starve_d;

    assign pipe_wr = pipe_wen && pipe_rd != X0;

    // Bypass needs no ll_ready term: with no live entry the FIFO is either not full or
    // is reclaiming a dead head, so ll_ready is already 1.
    always_comb begin
        sel = SRC_NONE;
        if (pipe_wr)
            sel = SRC_PIPE;
        else if (live_any)
            sel = SRC_FIFO;
        else if (ll_valid && ll_rd != X0)
            sel = SRC_BYPASS;
    end

    assign pop      = (sel == SRC_FIFO);
    assign ll_ready = !rst && (!full || retire);
    assign ll_fire  = ll_valid && ll_ready;
    assign push     = ll_fire && ll_rd != X0 && sel != SRC_BYPASS
                      && !(pipe_wr && ll_rd == pipe_rd);

    wb_ll_fifo #(
        .XLEN    (XLEN),
        .RA_W    (RA_W),
        .Q_DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_rd    (ll_rd),
        .push_wdata (ll_wdata),
        .pop        (pop),
        .kill       (pipe_wr),
        .kill_rd    (pipe_rd),
        .chk_rd     (chk_rd),
        .chk_hit    (fifo_hit),
        .live_any   (live_any),
        .head_rd    (head_rd),
        .head_wdata (head_wdata),
        .full       (full),
        .retire     (retire)
    );

    assign chk_hit = chk_rd != X0 && (fifo_hit || (ll_valid && ll_rd == chk_rd));

    always_comb begin
        req_d = '0;
        case (sel)
            SRC_PIPE:   req_d = '{wen: 1'b1, rd: pipe_rd, wdata: pipe_wdata};
            SRC_FIFO:   req_d = '{wen: 1'b1, rd: head_rd, wdata: head_wdata};
            SRC_BYPASS: req_d = '{wen: 1'b1, rd: ll_rd,   wdata: ll_wdata};
            default:    req_d = '0;
        endcase
    end

    always_comb begin
        if (pop || !live_any)
            starve_d = '0;
        else if (starve_q >= LIMIT)
            starve_d = LIMIT;
        else
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= '0;
            starve_q  <= '0;
            pipe_hold <= 1'b0;
        end else begin
            req_q     <= req_d;
            starve_q  <= starve_d;
            pipe_hold <= (starve_d == LIMIT);
        end
    end

    assign rf_wen   = req_q.wen;
    assign rf_rd    = req_q.rd;
    assign rf_wdata = req_q.wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: bypass, queueing, starvation hold, WAW kill,
// x0 handling and mid-stream reset with hand-computed expectations.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_wen = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_wdata = '0;
    logic        ll_valid = 1'b0;
    logic [4:0]  ll_rd = '0;
    logic [31:0] ll_wdata = '0;
    logic        ll_ready, pipe_hold, chk_hit, rf_wen;
    logic [4:0]  chk_rd = '0;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int n_cmp = 0;
    int n_err = 0;

    wb_port_arbiter #(
        .XLEN(32), .RA_W(5), .Q_DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
        .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_wdata(ll_wdata), .ll_ready(ll_ready),
        .pipe_hold(pipe_hold), .chk_rd(chk_rd), .chk_hit(chk_hit),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rf(input string tag, input logic wen, input logic [4:0] rd,
                            input logic [31:0] data);
        check({tag, ".wen"}, rf_wen, wen);
        if (wen) begin
            check({tag, ".rd"}, rf_rd, rd);
            check({tag, ".wdata"}, rf_wdata, data);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst.rf", {rf_wen, rf_rd, rf_wdata}, '0);
        check("rst.hold", pipe_hold, 1'b0);
        check("rst.ll_ready", ll_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rel.ll_ready", ll_ready, 1'b1);

        // Bypass on an idle slot
        ll_valid = 1'b1; ll_rd = 5'd5; ll_wdata = 32'hDEADBEEF; chk_rd = 5'd5;
        #1;
        check("byp.ll_ready", ll_ready, 1'b1);
        check("byp.chk_inflight", chk_hit, 1'b1);
        tick();
        ll_valid = 1'b0;
        #1;
        check_rf("byp.rf", 1'b1, 5'd5, 32'hDEADBEEF);
        check("byp.not_queued", chk_hit, 1'b0);
        tick();
        check("byp.idle", rf_wen, 1'b0);

        // Pipeline owns the port; LL results queue (cycle E)
        pipe_wen = 1'b1; pipe_rd = 5'd3; pipe_wdata = 32'hAAAA0001;
        ll_valid = 1'b1; ll_rd = 5'd7; ll_wdata = 32'h77; chk_rd = 5'd7;
        #1;
        check("q.ready0", ll_ready, 1'b1);
        tick();                                  // E+1
        check_rf("q.pipe1", 1'b1, 5'd3, 32'hAAAA0001);
        check("q.chk7", chk_hit, 1'b1);
        ll_rd = 5'd8; ll_wdata = 32'h88;
        #1;
        check("q.ready1", ll_ready, 1'b1);
        tick();                                  // E+2: FIFO full
        ll_rd = 5'd9; ll_wdata = 32'h99;         // held until accepted
        #1;
        check("q.full_ready", ll_ready, 1'b0);
        check("q.hold_e2", pipe_hold, 1'b0);
        tick();                                  // E+3
        check_rf("q.pipe3", 1'b1, 5'd3, 32'hAAAA0001);
        tick();                                  // E+4
        check("starve.hold_e4", pipe_hold, 1'b0);
        tick();                                  // E+5
        check("starve.hold_e5", pipe_hold, 1'b1);
        check("starve.ready_e5", ll_ready, 1'b0);
        pipe_wen = 1'b0;                         // bubble: head rd=7 pops, rd=9 pushes
        #1;
        check("starve.pop_ready", ll_ready, 1'b1);
        tick();                                  // E+6
        ll_valid = 1'b0;
        check_rf("starve.drain7", 1'b1, 5'd7, 32'h77);
        check("starve.hold_fall", pipe_hold, 1'b0);

        // WAW kill of queued rd=9
        pipe_wen = 1'b1; pipe_rd = 5'd9; pipe_wdata = 32'h11; chk_rd = 5'd9;
        #1;
        check("waw.chk_before", chk_hit, 1'b1);
        tick();                                  // E+7
        pipe_wen = 1'b0;
        #1;
        check_rf("waw.pipe9", 1'b1, 5'd9, 32'h11);
        check("waw.chk_after", chk_hit, 1'b0);
        tick();                                  // E+8
        check_rf("waw.drain8", 1'b1, 5'd8, 32'h88);
        tick();                                  // E+9
        check("waw.no_stale9", rf_wen, 1'b0);

        // x0 handling
        pipe_wen = 1'b1; pipe_rd = 5'd0; pipe_wdata = 32'h1234;
        ll_valid = 1'b1; ll_rd = 5'd0; ll_wdata = 32'h5555; chk_rd = 5'd0;
        #1;
        check("x0.ll_ready", ll_ready, 1'b1);
        check("x0.chk", chk_hit, 1'b0);
        tick();
        check("x0.no_write", rf_wen, 1'b0);

        // Two entries fill the FIFO exactly, so the x0 result was not queued
        pipe_rd = 5'd3; pipe_wdata = 32'hAAAA0002;
        ll_rd = 5'd10; ll_wdata = 32'hA0; chk_rd = 5'd10;
        tick();
        ll_rd = 5'd11; ll_wdata = 32'hB0;
        tick();
        ll_rd = 5'd12; ll_wdata = 32'hC0;
        #1;
        check("x0.occ_full", ll_ready, 1'b0);
        check("mrst.chk_before", chk_hit, 1'b1);

        // Asynchronous reset with two queued entries
        rst = 1'b1;
        #1;
        check("mrst.ll_ready", ll_ready, 1'b0);
        check("mrst.rf_wen", rf_wen, 1'b0);
        check("mrst.chk_cleared", chk_hit, 1'b0);
        tick();
        check("mrst.rf_wen_clk", rf_wen, 1'b0);
        ll_valid = 1'b0; pipe_wen = 1'b0;
        rst = 1'b0;
        #1;
        check("mrst.ready_after", ll_ready, 1'b1);
        tick();
        check("mrst.empty", rf_wen, 1'b0);
        check("mrst.hold", pipe_hold, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Front end must not write back while a bubble is requested.
    always @(negedge clk)
        if (!rst && pipe_hold && pipe_wen)
            $display("protocol warning: pipe_wen asserted while pipe_hold at %0t", $time);

endmodule
